// File: rtl/ste_snd_fifo.sv
// DMA sound sample FIFO: captures MCU memory words on SLOAD_N falling edges and
// unpacks them into left/right audio samples on each sample-rate tick.
module ste_snd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk32,
  input  logic          res,
  input  logic          EN,
  input  logic [1:0]    MODE,
  input  logic          SLOAD_N,
  input  logic [15:0]   MDIN,
  input  logic          STICK,
  output logic          SREQ,
  output logic [15:0]   audio_left,
  output logic [15:0]   audio_right,
  output logic [AW:0]   LEVEL,
  output logic          OVR,
  output logic          UDR
);

  localparam int unsigned CW = AW + 1;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          phase, sload_q, en_q;
  logic [1:0]    mode_q;

  logic          en_rise, wr_evt, wr_ok, wr_full;
  logic [1:0]    mode_in, mode_eff, pop_n;
  logic          avail, upd, udr_set, phase_nx;
  logic [15:0]   rd0, rd1, left_nx, right_nx;
  logic [CW-1:0] count_nx;
  logic          sreq_nx;

  // Write/pop decode; every term is evaluated against the count before this cycle's update.
  always_comb begin
    en_rise  = EN & ~en_q;
    mode_in  = (MODE == 2'b11) ? 2'b00 : MODE;
    mode_eff = en_rise ? mode_in : mode_q;
    wr_evt   = EN & sload_q & ~SLOAD_N & ~res;
    wr_full  = wr_evt & (LEVEL == CW'(DEPTH));
    wr_ok    = wr_evt & ~wr_full;
    rd0      = mem[rp];
    rd1      = mem[rp + AW'(1)];
    avail    = (mode_eff == 2'b10) ? (LEVEL >= CW'(2)) : (LEVEL != CW'(0));
    upd      = EN & STICK & avail;
    udr_set  = EN & STICK & ~avail;
    pop_n    = 2'd0;
    phase_nx = phase;
    left_nx  = audio_left;
    right_nx = audio_right;
    if (upd) begin
      case (mode_eff)
        2'b01: begin
          // Mono: high byte first without consuming, then low byte and pop.
          left_nx  = phase ? {rd0[7:0], 8'h00} : {rd0[15:8], 8'h00};
          right_nx = left_nx;
          pop_n    = phase ? 2'd1 : 2'd0;
          phase_nx = ~phase;
        end
        2'b10: begin
          left_nx  = rd0;
          right_nx = rd1;
          pop_n    = 2'd2;
        end
        default: begin
          left_nx  = {rd0[15:8], 8'h00};
          right_nx = {rd0[7:0], 8'h00};
          pop_n    = 2'd1;
        end
      endcase
    end
    count_nx = LEVEL + CW'(wr_ok) - CW'(pop_n);
    sreq_nx  = EN & (count_nx <= CW'(DEPTH - 2));
  end

  always_ff @(posedge clk32) begin
    if (wr_ok) mem[wp] <= MDIN;
  end

  // Control state; EN low holds the FIFO flushed while the sticky flags survive.
  always_ff @(posedge clk32 or posedge res) begin
    if (res) begin
      wp          <= '0;
      rp          <= '0;
      LEVEL       <= '0;
      phase       <= 1'b0;
      SREQ        <= 1'b0;
      audio_left  <= '0;
      audio_right <= '0;
      OVR         <= 1'b0;
      UDR         <= 1'b0;
      mode_q      <= 2'b00;
      sload_q     <= 1'b1;
      en_q        <= 1'b0;
    end else begin
      sload_q <= SLOAD_N;
      en_q    <= EN;
      SREQ    <= sreq_nx;
      if (!EN) begin
        wp          <= '0;
        rp          <= '0;
        LEVEL       <= '0;
        phase       <= 1'b0;
        audio_left  <= '0;
        audio_right <= '0;
      end else begin
        if (en_rise) begin
          mode_q <= mode_in;
          OVR    <= 1'b0;
          UDR    <= 1'b0;
        end
        if (wr_ok)   wp  <= wp + AW'(1);
        if (wr_full) OVR <= 1'b1;
        if (udr_set) UDR <= 1'b1;
        rp          <= rp + AW'(pop_n);
        LEVEL       <= count_nx;
        phase       <= phase_nx;
        audio_left  <= left_nx;
        audio_right <= right_nx;
      end
    end
  end

endmodule

// File: tb/tb_ste_snd_fifo.sv
// Bench for ste_snd_fifo: directed scenarios plus random traffic against a queue model.
module tb_ste_snd_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic        clk32 = 1'b0;
  logic        res = 1'b1;
  logic        EN = 1'b0;
  logic [1:0]  MODE = 2'b00;
  logic        SLOAD_N = 1'b1;
  logic [15:0] MDIN = '0;
  logic        STICK = 1'b0;
  logic        SREQ, OVR, UDR;
  logic [15:0] audio_left, audio_right;
  logic [AW:0] LEVEL;

  int checks = 0;
  int errors = 0;

  ste_snd_fifo #(.DEPTH(DEPTH)) dut (
    .clk32(clk32), .res(res), .EN(EN), .MODE(MODE), .SLOAD_N(SLOAD_N),
    .MDIN(MDIN), .STICK(STICK), .SREQ(SREQ), .audio_left(audio_left),
    .audio_right(audio_right), .LEVEL(LEVEL), .OVR(OVR), .UDR(UDR)
  );

  always #5 clk32 = ~clk32;

  // Reference model state
  logic [15:0] q[$];
  logic [15:0] m_l, m_r;
  logic        m_phase, m_ovr, m_udr, m_sreq, m_sl_prev, m_en_prev;
  int          m_mode;
  logic [1:0]  cur_mode = 2'b00;

  task automatic model_reset();
    q.delete();
    m_l = '0; m_r = '0; m_phase = 0; m_ovr = 0; m_udr = 0; m_sreq = 0;
    m_sl_prev = 1; m_en_prev = 0; m_mode = 0;
  endtask

  task automatic model_step(input logic en, input logic [1:0] mode, input logic sl,
                            input logic [15:0] d, input logic st);
    logic fall;
    int n, need, pops;
    logic [15:0] w0, w1;
    fall = m_sl_prev && !sl;
    m_sl_prev = sl;
    if (!en) begin
      q.delete(); m_phase = 0; m_l = '0; m_r = '0; m_sreq = 0; m_en_prev = 0;
    end else begin
      if (!m_en_prev) begin
        m_mode = (mode == 2'd3) ? 0 : int'(mode);
        m_ovr = 0; m_udr = 0;
      end
      m_en_prev = 1;
      n = q.size();
      pops = 0;
      if (st) begin
        need = (m_mode == 2) ? 2 : 1;
        if (n < need) m_udr = 1;
        else begin
          w0 = q[0];
          w1 = (n > 1) ? q[1] : 16'h0;
          if (m_mode == 0) begin
            m_l = {w0[15:8], 8'h00}; m_r = {w0[7:0], 8'h00}; pops = 1;
          end else if (m_mode == 1) begin
            m_l = m_phase ? {w0[7:0], 8'h00} : {w0[15:8], 8'h00};
            m_r = m_l;
            pops = m_phase ? 1 : 0;
            m_phase = !m_phase;
          end else begin
            m_l = w0; m_r = w1; pops = 2;
          end
        end
      end
      if (fall) begin
        if (n == DEPTH) m_ovr = 1;
        else q.push_back(d);
      end
      repeat (pops) void'(q.pop_front());
      m_sreq = (q.size() <= DEPTH - 2);
    end
  endtask

  task automatic cycle(input logic en, input logic [1:0] mode, input logic sl,
                       input logic [15:0] d, input logic st);
    EN = en; MODE = mode; SLOAD_N = sl; MDIN = d; STICK = st;
    @(posedge clk32);
    model_step(en, mode, sl, d, st);
    #1;
  endtask

  task automatic wr(input logic [15:0] w);
    cycle(1'b1, cur_mode, 1'b0, w, 1'b0);
    cycle(1'b1, cur_mode, 1'b1, w, 1'b0);
  endtask

  task automatic tick();
    cycle(1'b1, cur_mode, 1'b1, 16'h0, 1'b1);
  endtask

  task automatic restart(input logic [1:0] mode);
    cur_mode = mode;
    cycle(1'b0, mode, 1'b1, 16'h0, 1'b0);
    cycle(1'b1, mode, 1'b1, 16'h0, 1'b0);
  endtask

  task automatic test_reset();
    res = 1; EN = 0; SLOAD_N = 1; STICK = 0; MODE = 0; MDIN = 0;
    repeat (2) @(posedge clk32);
    #1;
    model_reset();
    checks++;
    if ({SREQ, audio_left, audio_right, LEVEL, OVR, UDR} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h/%h/%h/%h/%b/%b required all zero",
               SREQ, audio_left, audio_right, LEVEL, OVR, UDR);
    end
    res = 0;
  endtask

  task automatic test_basic();
    restart(2'b00);
    wr(16'h7F80);
    tick();
    checks++;
    if (audio_left !== 16'h7F00 || audio_right !== 16'h8000 || LEVEL !== 4'd0) begin
      errors++;
      $display("FAIL basic_stereo8: got L=%h R=%h lvl=%0d required 7f00 8000 0",
               audio_left, audio_right, LEVEL);
    end
  endtask

  task automatic test_overrun();
    logic [15:0] w[9];
    int exp_lvl;
    restart(2'b00);
    for (int i = 0; i < 9; i++) begin
      w[i] = 16'($urandom);
      wr(w[i]);
      exp_lvl = (i + 1 > 8) ? 8 : i + 1;
      checks++;
      if (LEVEL !== 4'(exp_lvl) || SREQ !== (exp_lvl <= 6)) begin
        errors++;
        $display("FAIL fill_%0d: got lvl=%0d sreq=%b required lvl=%0d sreq=%b",
                 i, LEVEL, SREQ, exp_lvl, exp_lvl <= 6);
      end
    end
    checks++;
    if (OVR !== 1'b1 || UDR !== 1'b0) begin
      errors++;
      $display("FAIL overrun_flag: got ovr=%b udr=%b required 1 0", OVR, UDR);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (audio_left !== {w[i][15:8], 8'h00} || audio_right !== {w[i][7:0], 8'h00}) begin
        errors++;
        $display("FAIL readback_%0d: got %h %h required word %h", i, audio_left, audio_right, w[i]);
      end
    end
    tick();
    checks++;
    if (UDR !== 1'b1 || LEVEL !== 4'd0) begin
      errors++;
      $display("FAIL drain_underrun: got udr=%b lvl=%0d required 1 0", UDR, LEVEL);
    end
  endtask

  task automatic test_mono();
    restart(2'b01);
    wr(16'h1234);
    tick();
    checks++;
    if (audio_left !== 16'h1200 || audio_right !== 16'h1200 || LEVEL !== 4'd1) begin
      errors++;
      $display("FAIL mono_hi: got %h %h lvl=%0d required 1200 1200 1", audio_left, audio_right, LEVEL);
    end
    tick();
    checks++;
    if (audio_left !== 16'h3400 || audio_right !== 16'h3400 || LEVEL !== 4'd0) begin
      errors++;
      $display("FAIL mono_lo: got %h %h lvl=%0d required 3400 3400 0", audio_left, audio_right, LEVEL);
    end
  endtask

  task automatic test_stereo16();
    restart(2'b10);
    wr(16'hAAAA);
    tick();
    checks++;
    if (UDR !== 1'b1 || audio_left !== 16'h0 || audio_right !== 16'h0 || LEVEL !== 4'd1) begin
      errors++;
      $display("FAIL s16_underrun: got udr=%b %h %h lvl=%0d required 1 0 0 1",
               UDR, audio_left, audio_right, LEVEL);
    end
    wr(16'h5555);
    tick();
    checks++;
    if (audio_left !== 16'hAAAA || audio_right !== 16'h5555 || LEVEL !== 4'd0) begin
      errors++;
      $display("FAIL s16_pop: got %h %h lvl=%0d required aaaa 5555 0", audio_left, audio_right, LEVEL);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w[4];
    restart(2'b00);
    for (int i = 0; i < 4; i++) w[i] = 16'($urandom);
    for (int i = 0; i < 3; i++) wr(w[i]);
    cycle(1'b1, 2'b00, 1'b0, w[3], 1'b1);
    checks++;
    if (LEVEL !== 4'd3 || audio_left !== {w[0][15:8], 8'h00} || audio_right !== {w[0][7:0], 8'h00}) begin
      errors++;
      $display("FAIL simul_wr_pop: got lvl=%0d %h %h required 3 oldest %h", LEVEL, audio_left, audio_right, w[0]);
    end
    cycle(1'b1, 2'b00, 1'b1, 16'h0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick();
      checks++;
      if (audio_left !== {w[i][15:8], 8'h00} || audio_right !== {w[i][7:0], 8'h00}) begin
        errors++;
        $display("FAIL simul_order_%0d: got %h %h required word %h", i, audio_left, audio_right, w[i]);
      end
    end
  endtask

  task automatic test_en_drop();
    restart(2'b00);
    tick();
    for (int i = 0; i < 6; i++) wr(16'hF0F0 + 16'(i));
    tick();
    checks++;
    if (LEVEL !== 4'd5 || audio_left !== 16'hF000) begin
      errors++;
      $display("FAIL pre_drop: got lvl=%0d L=%h required 5 f000", LEVEL, audio_left);
    end
    cycle(1'b0, 2'b00, 1'b1, 16'h0, 1'b0);
    checks++;
    if (LEVEL !== 4'd0 || audio_left !== 16'h0 || audio_right !== 16'h0 || SREQ !== 1'b0 || UDR !== 1'b1) begin
      errors++;
      $display("FAIL en_drop: got lvl=%0d %h %h sreq=%b udr=%b required 0 0 0 0 1",
               LEVEL, audio_left, audio_right, SREQ, UDR);
    end
    cycle(1'b0, 2'b00, 1'b1, 16'h0, 1'b0);
    cycle(1'b1, 2'b00, 1'b1, 16'h0, 1'b0);
    checks++;
    if (UDR !== 1'b0 || OVR !== 1'b0 || SREQ !== 1'b1) begin
      errors++;
      $display("FAIL en_rise_clear: got udr=%b ovr=%b sreq=%b required 0 0 1", UDR, OVR, SREQ);
    end
  endtask

  task automatic test_reset_mid();
    restart(2'b00);
    for (int i = 0; i < 3; i++) wr(16'h1111 * 16'(i + 1));
    tick();
    EN = 1; SLOAD_N = 0; STICK = 1;
    #2 res = 1;
    #1;
    checks++;
    if ({SREQ, audio_left, audio_right, LEVEL, OVR, UDR} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got %b/%h/%h/%0d/%b/%b required all zero",
               SREQ, audio_left, audio_right, LEVEL, OVR, UDR);
    end
    SLOAD_N = 1; STICK = 0; EN = 0;
    @(posedge clk32);
    #1;
    model_reset();
    res = 0;
  endtask

  task automatic test_random();
    logic en;
    logic [1:0] mode;
    en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 2) en = !en;
      mode = 2'($urandom);
      cycle(en, mode, 1'($urandom), 16'($urandom), $urandom_range(0, 3) == 0);
      checks++;
      if ({SREQ, audio_left, audio_right, LEVEL, OVR, UDR} !==
          {m_sreq, m_l, m_r, 4'(q.size()), m_ovr, m_udr}) begin
        errors++;
        $display("FAIL random_%0d: got sreq=%b L=%h R=%h lvl=%0d ovr=%b udr=%b required %b %h %h %0d %b %b",
                 c, SREQ, audio_left, audio_right, LEVEL, OVR, UDR,
                 m_sreq, m_l, m_r, q.size(), m_ovr, m_udr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_mono();
    test_stereo16();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ste_snd_fifo.md
STE_SND_FIFO -- requirements
Module: ste_snd_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO depth in 16-bit words; power of two, minimum 4.
REQ-002 Parameter AW, default $clog2(DEPTH), pointer width; count width is AW+1.
REQ-003 Port clk32  in  1  system clock; all state on rising edge.
REQ-004 Port res  in  1  reset, asynchronous, active-high.
REQ-005 Port EN  in  1  DMA sound enable, level.
REQ-006 Port MODE  in  2  frame format: 00 = 8-bit stereo, 01 = 8-bit mono, 10 = 16-bit stereo, 11 = reserved and treated as 00.
REQ-007 Port SLOAD_N  in  1  load strobe from the MCU, active low.
REQ-008 Port MDIN  in  16  memory data word, valid while SLOAD_N is low.
REQ-009 Port STICK  in  1  sample-rate tick, one-cycle pulse.
REQ-010 Port SREQ  out  1  DMA sound request to the MCU.
REQ-011 Port audio_left  out  16  signed left sample.
REQ-012 Port audio_right  out  16  signed right sample.
REQ-013 Port LEVEL  out  AW+1  current FIFO occupancy in words.
REQ-014 Port OVR  out  1  sticky overrun flag.
REQ-015 Port UDR  out  1  sticky underrun flag.

Function
REQ-016 Write: a falling edge of SLOAD_N (registered previous value 1, current value 0) SHALL write MDIN at the write pointer while EN=1; count increments and the pointer wraps modulo DEPTH.
REQ-017 A write when count==DEPTH SHALL be dropped (no pointer or count change) and SHALL set OVR.
REQ-018 A SLOAD_N falling edge while EN=0 SHALL be ignored without setting a flag.
REQ-019 SREQ SHALL be registered: SREQ <= EN & (count_next <= DEPTH-2); it is low on the cycle after EN falls.
REQ-020 Mode latch: MODE SHALL be captured on the rising edge of EN; MODE changes while EN=1 SHALL have no effect.
REQ-021 Pop on STICK=1 with EN=1, per latched mode:
- 00: needs count>=1; pops 1 word; left={w[15:8],8'h00}, right={w[7:0],8'h00}.
- 01: needs count>=1; phase bit P; P=0 outputs {w[15:8],8'h00} on both channels without popping, then P<=1; P=1 outputs {w[7:0],8'h00} on both, pops, then P<=0.
- 10: needs count>=2; pops 2 words; left=first word, right=second word.
REQ-022 Outputs SHALL update on the cycle following STICK (1-cycle latency) and hold between ticks.
REQ-023 Underrun: STICK with insufficient words SHALL pop nothing, hold the outputs, leave P unchanged and set UDR.
REQ-024 Simultaneous write and pop in one cycle: both SHALL occur; count_next = count + 1 - popped; the full check uses the count before the pop.
REQ-025 EN falling: FIFO flushed (pointers, count, P cleared); audio outputs cleared to 0; OVR and UDR retained.
REQ-026 EN rising: OVR and UDR cleared.
REQ-027 LEVEL SHALL equal the registered count.

Reset
REQ-028 While res=1: pointers, count, LEVEL=0; P=0; SREQ=0; audio_left and audio_right=0; OVR and UDR=0; latched mode=00; SLOAD_N history register=1.
REQ-029 Reset asserted mid-operation SHALL abort at once with no partial write or pop; the first write after release requires a fresh SLOAD_N falling edge.

Verification
REQ-030 Reset, EN=1, MODE=00, write 16'h7F80, STICK -> next cycle left=16'h7F00, right=16'h8000, LEVEL=0.
REQ-031 DEPTH=8, EN=1, nine SLOAD_N pulses with no STICK -> LEVEL=8, OVR=1, SREQ=0 from LEVEL=7 onward, ninth word absent on readback.
REQ-032 MODE=01, write 16'h1234, two STICKs -> first both channels 16'h1200, LEVEL=1; second both channels 16'h3400, LEVEL=0.
REQ-033 MODE=10, write 16'hAAAA, STICK -> UDR=1, outputs unchanged; write 16'h5555, STICK -> left=16'hAAAA, right=16'h5555.
REQ-034 LEVEL=3, SLOAD_N falling edge and STICK in the same cycle (MODE=00) -> LEVEL stays 3 and the popped word is the oldest.
REQ-035 EN dropped with LEVEL=5 -> next cycle LEVEL=0, outputs=0, SREQ=0; flags kept until EN rises again.
